three_input_debouncer: RTL and testbench

// - Upstream conditioning stage for the 3-input NOR: takes three raw switch/button levels and produces three clean, synchronized, debounced levels.
// - Each channel runs a 2-FF synchronizer, then a stability counter. Outputs a,b,c drive the NOR gate inputs directly.

---
 rtl/debounce_pkg.sv | 13 +
 rtl/three_input_debouncer_if.sv | 38 +++
 rtl/debounce_channel.sv | 106 ++++++++++
 rtl/three_input_debouncer.sv | 75 +++++++
 tb/tb_three_input_debouncer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the three-channel switch debouncer.
package debounce_pkg;

    // Per-channel state: STABLE while out tracks sync, COUNTING while a new level is being qualified
    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } ch_state_e;

    localparam int unsigned DEF_STABLE_CYCLES = 4;
    localparam int unsigned DEF_CNT_W         = 16;

endpackage

// File: rtl/three_input_debouncer_if.sv
// Raw switch levels in, debounced levels and strobes out.
// DEBOUNCE_RISE_PULSE_EN adds the per-channel rising-edge pulses.
interface three_input_debouncer_if;

    logic a_raw;
    logic b_raw;
    logic c_raw;
    logic a;
    logic b;
    logic c;
    logic changed;
`ifdef DEBOUNCE_RISE_PULSE_EN
    logic a_rise;
    logic b_rise;
    logic c_rise;

    modport master (
        output a_raw, b_raw, c_raw,
        input  a, b, c, changed, a_rise, b_rise, c_rise
    );

    modport slave (
        input  a_raw, b_raw, c_raw,
        output a, b, c, changed, a_rise, b_rise, c_rise
    );
`else
    modport master (
        output a_raw, b_raw, c_raw,
        input  a, b, c, changed
    );

    modport slave (
        input  a_raw, b_raw, c_raw,
        output a, b, c, changed
    );
`endif

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchronizer, then a stability counter gating the output.
// DEBOUNCE_RISE_PULSE_EN adds the registered rise pulse.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic out,
    output logic accept
`ifdef DEBOUNCE_RISE_PULSE_EN
    ,
    output logic rise
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    ch_state_e        state_q;
    ch_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;
    logic             out_d;
    logic             rise_d;

    // Metastability guard: raw is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Counter only climbs to CNT_LAST before the state leaves COUNTING, so it never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        accept  = 1'b0;
        rise_d  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync2_q != out_q) begin
                    state_d = ST_COUNTING;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_COUNTING: begin
                if (sync2_q == out_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    out_d   = sync2_q;
                    accept  = 1'b1;
                    rise_d  = sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign out = out_q;

`ifdef DEBOUNCE_RISE_PULSE_EN
    logic rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;
`else
    logic unused_rise;
    assign unused_rise = rise_d;
`endif

endmodule

// File: rtl/three_input_debouncer.sv
// Conditions three raw switch levels into clean debounced inputs for the 3-input NOR.
// DEBOUNCE_RISE_PULSE_EN adds a_rise/b_rise/c_rise.
module three_input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input logic                    clk,
    input logic                    rst_n,
    three_input_debouncer_if.slave dbus
);

    logic accept_a;
    logic accept_b;
    logic accept_c;
    logic changed_q;

    debounce_channel #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (dbus.a_raw),
        .out    (dbus.a),
        .accept (accept_a)
`ifdef DEBOUNCE_RISE_PULSE_EN
        ,
        .rise   (dbus.a_rise)
`endif
    );

    debounce_channel #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (dbus.b_raw),
        .out    (dbus.b),
        .accept (accept_b)
`ifdef DEBOUNCE_RISE_PULSE_EN
        ,
        .rise   (dbus.b_rise)
`endif
    );

    debounce_channel #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_c (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (dbus.c_raw),
        .out    (dbus.c),
        .accept (accept_c)
`ifdef DEBOUNCE_RISE_PULSE_EN
        ,
        .rise   (dbus.c_rise)
`endif
    );

    // Coincident accepts on several channels merge into one strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= accept_a | accept_b | accept_c;
        end
    end

    assign dbus.changed = changed_q;

endmodule

// File: tb/tb_three_input_debouncer.sv
// Directed bench for three_input_debouncer with STABLE_CYCLES=4.
// Build with DEBOUNCE_RISE_PULSE_EN to also cover the rise pulses.
module tb_three_input_debouncer;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   chg_total;
    int   base;
`ifdef DEBOUNCE_RISE_PULSE_EN
    int   rise_total;
    int   rbase;
`endif

    three_input_debouncer_if dbus ();

    three_input_debouncer #(
        .STABLE_CYCLES (4),
        .CNT_W         (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbus  (dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running count of changed strobes, sampled mid-cycle
    initial chg_total = 0;
    always @(negedge clk) if (dbus.changed) chg_total <= chg_total + 1;

`ifdef DEBOUNCE_RISE_PULSE_EN
    initial rise_total = 0;
    always @(negedge clk) if (dbus.a_rise) rise_total <= rise_total + 1;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] abc();
        return 32'({dbus.a, dbus.b, dbus.c});
    endfunction

    function automatic logic [31:0] chg();
        return 32'(dbus.changed);
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        dbus.a_raw = 1'b0;
        dbus.b_raw = 1'b0;
        dbus.c_raw = 1'b0;

        // Reset holds everything low even with all raws high
        dbus.a_raw = 1'b1;
        dbus.b_raw = 1'b1;
        dbus.c_raw = 1'b1;
        step_n(3);
        check_val("rst_abc", abc(), 32'h0);
        check_val("rst_chg", chg(), 32'h0);
        rst_n = 1'b1;
        step_n(5);
        check_val("rel5_abc", abc(), 32'h0);
        step_n(1);
        check_val("rel6_abc", abc(), 32'h7);
        check_val("rel6_chg", chg(), 32'h1);
        step_n(1);
        check_val("rel7_chg", chg(), 32'h0);
        check_val("rel7_abc", abc(), 32'h7);

        dbus.a_raw = 1'b0;
        dbus.b_raw = 1'b0;
        dbus.c_raw = 1'b0;
        step_n(6);
        check_val("fall_abc", abc(), 32'h0);
        step_n(2);

        // Three-cycle glitch on a never propagates
        base = chg_total;
        dbus.a_raw = 1'b1;
        step_n(3);
        dbus.a_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step_n(1);
            check_val("glitch_a", 32'(dbus.a), 32'h0);
        end
        check_val("glitch_pulses", 32'(chg_total - base), 32'h0);

        // Four-cycle press is just long enough to be accepted
        base = chg_total;
`ifdef DEBOUNCE_RISE_PULSE_EN
        rbase = rise_total;
`endif
        dbus.a_raw = 1'b1;
        step_n(4);
        dbus.a_raw = 1'b0;
        step_n(1);
        check_val("min_e5_a", 32'(dbus.a), 32'h0);
        step_n(1);
        check_val("min_e6_a", 32'(dbus.a), 32'h1);
        check_val("min_e6_chg", chg(), 32'h1);
`ifdef DEBOUNCE_RISE_PULSE_EN
        check_val("min_e6_rise", 32'(dbus.a_rise), 32'h1);
`endif
        step_n(1);
        check_val("min_e7_a", 32'(dbus.a), 32'h1);
        check_val("min_e7_chg", chg(), 32'h0);
`ifdef DEBOUNCE_RISE_PULSE_EN
        check_val("min_e7_rise", 32'(dbus.a_rise), 32'h0);
`endif
        step_n(2);
        check_val("min_e9_a", 32'(dbus.a), 32'h1);
        step_n(1);
        check_val("min_e10_a", 32'(dbus.a), 32'h0);
        check_val("min_e10_chg", chg(), 32'h1);
`ifdef DEBOUNCE_RISE_PULSE_EN
        check_val("min_e10_rise", 32'(dbus.a_rise), 32'h0);
`endif
        step_n(2);
        check_val("min_pulses", 32'(chg_total - base), 32'h2);
`ifdef DEBOUNCE_RISE_PULSE_EN
        check_val("min_rises", 32'(rise_total - rbase), 32'h1);
`endif

        // Clean press and release on b
        base = chg_total;
        dbus.b_raw = 1'b1;
        step_n(5);
        check_val("press5_b", 32'(dbus.b), 32'h0);
        step_n(1);
        check_val("press6_b", 32'(dbus.b), 32'h1);
        check_val("press6_chg", chg(), 32'h1);
        step_n(1);
        check_val("press7_chg", chg(), 32'h0);
        step_n(20);
        dbus.b_raw = 1'b0;
        step_n(5);
        check_val("rel5_b", 32'(dbus.b), 32'h1);
        step_n(1);
        check_val("rel6_b", 32'(dbus.b), 32'h0);
        check_val("rel6b_chg", chg(), 32'h1);
        step_n(2);
        check_val("press_pulses", 32'(chg_total - base), 32'h2);

        // Simultaneous a and c produce one strobe
        base = chg_total;
        dbus.a_raw = 1'b1;
        dbus.c_raw = 1'b1;
        step_n(5);
        check_val("sim5_abc", abc(), 32'h0);
        step_n(1);
        check_val("sim6_abc", abc(), 32'h5);
        check_val("sim6_chg", chg(), 32'h1);
        step_n(1);
        check_val("sim7_chg", chg(), 32'h0);
        step_n(2);
        check_val("sim_pulses", 32'(chg_total - base), 32'h1);

        // Reset mid-count clears settled and pending channels at once
        dbus.a_raw = 1'b0;
        dbus.c_raw = 1'b0;
        dbus.b_raw = 1'b1;
        step_n(8);
        check_val("pre_rst_abc", abc(), 32'h2);
        dbus.c_raw = 1'b1;
        step_n(4);
        rst_n = 1'b0;
        #2;
        check_val("mid_rst_abc", abc(), 32'h0);
        check_val("mid_rst_chg", chg(), 32'h0);
        step_n(2);
        rst_n = 1'b1;
        step_n(5);
        check_val("rerel5_abc", abc(), 32'h0);
        step_n(1);
        check_val("rerel6_abc", abc(), 32'h3);
        check_val("rerel6_chg", chg(), 32'h1);
        step_n(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
